mem_ctrl: RTL
=============

Name: mem_ctrl

Overview:
- Parametrised multi-cycle data-memory/UART access controller for the MEM stage.
- Replaces single-cycle combinational strobing with an FSM: configurable wait states on SRAM1 and the shared UART bus.
- Raises a stall to the pipeline-register enables while an access is in flight.
- Sits between the exe_mem register and the mem_wb register; owns the RAM1 control pins and UART strobes.

Parameters:
DATA_W, 16, data bus width (UART uses low 8 bits)
ADDR_W, 16, address width
WAIT_CYCLES, 1, extra strobe cycles beyond the first (0 legal)
UART_DATA_ADDR, 16'hBF00, UART data register address
UART_STAT_ADDR, 16'hBF01, UART status register address

Ports:
mci_clk  in  1  clock
mci_rst  in  1  asynchronous reset, active-low
mci_req_valid  in  1  access request; sampled only in IDLE
mci_req_we  in  1  1 = write, 0 = read
mci_req_addr  in  ADDR_W  access address
mci_req_wdata  in  DATA_W  write data
mco_stall  out  1  freeze upstream pipeline registers
mco_done  out  1  one-cycle completion pulse
mco_rdata  out  DATA_W  registered read data, valid with done and held until next done
mco_ram_en / mco_ram_we / mco_ram_oe  out  1 each  RAM1 strobes, active-low
mco_ram_addr  out  ADDR_W  RAM1 address
mco_ram_dout  out  DATA_W  data to bus
mco_ram_doe  out  1  bus drive enable; top level tri-states when 0
mci_ram_din  in  DATA_W  data from shared bus
mci_uart_tbre / mci_uart_tsre / mci_uart_data_ready  in  1 each  UART status
mco_uart_wrn / mco_uart_rdn  out  1 each  UART strobes, active-low

Behaviour:
- Reset (asynchronous, active-low) forces, immediately, including mid-access:
  - state=IDLE; strobes all 1; ram_doe=0; done=0; stall=0; rdata=0; ram_addr=0; counter=0.
- Interface decided: one clock mci_clk; reset mci_rst, asynchronous, active-low.
- States: IDLE, SRAM_RD, SRAM_WR, UART_RD, UART_WR, DONE.
- IDLE:
  - stall = req_valid (combinational).
  - On an edge with req_valid=1: latch addr/wdata/we, load counter=WAIT_CYCLES, enter the access state.
  - Access-state selection by address:
    - UART_STAT_ADDR read -> DONE directly; rdata = {0…, data_ready, tbre&tsre} (bit1 readable, bit0 writable).
    - UART_STAT_ADDR write -> DONE; ignored.
    - UART_DATA_ADDR -> UART_RD / UART_WR.
    - Any other address -> SRAM_RD / SRAM_WR.
- Access states (stall=1):
  - SRAM_RD: ram_en=0, ram_oe=0.
  - SRAM_WR: ram_en=0, ram_we=0, ram_doe=1.
  - UART_RD: rdn=0, ram_en=1.
  - UART_WR: wrn=0, ram_doe=1, ram_en=1.
  - Strobe held WAIT_CYCLES+1 cycles; counter decrements each cycle.
  - On the cycle counter==0, reads capture ram_din into rdata (UART: low 8 bits, zero-extended); then go to DONE.
- DONE:
  - done=1, stall=0, all strobes high, doe=0; next state IDLE.
  - A new request is not accepted in DONE.
- Latency:
  - Accept edge E. Strobe active cycles E..E+WAIT_CYCLES. Done asserted in the cycle after E+WAIT_CYCLES+1.
  - Status reads: done in the cycle after E+1.
- Throughput: one access per WAIT_CYCLES+3 cycles.
- ram_addr is driven from the latched address during access states and is 0 otherwise.
- Address and data are stable for the whole strobe window; doe never overlaps oe=0.
- req changes while busy are ignored. The requester holds req_valid/addr/data until done (guaranteed by stall).
- Counter width = max(1, $clog2(WAIT_CYCLES+1)).

Optional Feature:
MEM_CTRL_UART_BLOCK_EN
- Defined:
  - UART_RD inserts a UART_RD_WAIT state before asserting rdn; stays there (stall=1) until data_ready=1.
  - UART_WR inserts UART_WR_WAIT after the strobe; stays there until tbre=1 and then tsre=1, then DONE.
- Undefined: no wait states; software polls the status register. Behaviour exactly as above.

Decomposition:
- Package mem_ctrl_pkg: state enum; UART address defaults; status bit indices (STAT_TX_IDLE=0, STAT_RX_READY=1); strobe active level constant.
- One sub-module, mem_wait_timer: loadable down-counter, parametrised by WAIT_CYCLES, with a zero flag.

Test Plan:
- Reset pulse mid-SRAM_WR (WAIT_CYCLES=2) -> strobes high and doe=0 in the same cycle; rdata=0; no done.
- SRAM write addr 16'h4000 data 16'hBEEF, then read 16'h4000 (WAIT_CYCLES=1) -> we low exactly 2 cycles with doe=1; read done 3 cycles after accept with rdata=16'hBEEF; stall high from request until done.
- WAIT_CYCLES=0 back-to-back reads 16'h0001/16'h0002 -> oe low 1 cycle each; accepts spaced 3 cycles.
- Status read with data_ready=1, tbre=1, tsre=0 -> rdata=16'h0002, done one cycle after accept.
- UART read with ram_din=16'h1241 -> rdn low WAIT_CYCLES+1 cycles, rdata=16'h0041, ram_en=1 throughout.
- MEM_CTRL_UART_BLOCK_EN defined, UART write with tbre held 0 for 10 cycles -> stall held, no done until tbre and tsre are both 1.

Source files
------------

// File: rtl/mem_ctrl_pkg.sv
// Shared definitions for the MEM-stage memory/UART access controller.
// Holds the FSM state encodings, the UART register map defaults and status bit positions,
// the strobe polarity, and the counter width helper used by the wait timer.
package mem_ctrl_pkg;

  typedef logic [2:0] state_t;

  localparam state_t ST_IDLE         = 3'd0;
  localparam state_t ST_SRAM_RD      = 3'd1;
  localparam state_t ST_SRAM_WR      = 3'd2;
  localparam state_t ST_UART_RD      = 3'd3;
  localparam state_t ST_UART_WR      = 3'd4;
  localparam state_t ST_DONE         = 3'd5;
  localparam state_t ST_UART_RD_WAIT = 3'd6;
  localparam state_t ST_UART_WR_WAIT = 3'd7;

  localparam logic [15:0] UART_DATA_ADDR_DEF = 16'hBF00;
  localparam logic [15:0] UART_STAT_ADDR_DEF = 16'hBF01;

  // Status register layout: bit0 = transmitter idle, bit1 = receive data ready.
  localparam int STAT_TX_IDLE  = 0;
  localparam int STAT_RX_READY = 1;

  // All RAM and UART strobes are active-low.
  localparam logic STROBE_ON  = 1'b0;
  localparam logic STROBE_OFF = 1'b1;

  // States in which a bus strobe is asserted and the wait counter runs.
  function automatic logic is_strobe(input state_t s);
    return (s == ST_SRAM_RD) || (s == ST_SRAM_WR) || (s == ST_UART_RD) || (s == ST_UART_WR);
  endfunction

  // max(1, clog2(wait_cycles+1))
  function automatic int cnt_w(input int wait_cycles);
    int w;
    w = $clog2(wait_cycles + 1);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/mem_wait_timer.sv
// Loadable down-counter timing the strobe window of one access.
// Latency: zero_o reflects the registered count; a load takes effect on the next edge.
// Backpressure: none; it counts whenever dec_i is high and saturates at zero.
// Ports: clk_i/rst_ni clock and async active-low reset; load_i reloads WAIT_CYCLES;
//        dec_i decrements; zero_o is high while the count is zero.
module mem_wait_timer
  import mem_ctrl_pkg::*;
#(
  parameter int WAIT_CYCLES = 1
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic load_i,
  input  logic dec_i,
  output logic zero_o
);

  localparam int CW = cnt_w(WAIT_CYCLES);
  localparam logic [CW-1:0] LOAD_VAL = CW'(WAIT_CYCLES);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = LOAD_VAL;
    end else if (dec_i && (cnt_q != '0)) begin
      cnt_d = cnt_q - CW'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/mem_ctrl.sv
// Multi-cycle SRAM1 / UART access controller for the MEM stage.
// Latency: strobe held WAIT_CYCLES+1 cycles after accept, then a one-cycle done; status register accesses finish right after accept.
// Backpressure: mco_stall freezes the upstream pipeline from request until done; requests are only sampled in IDLE.
// Ports: mci_req_* request from exe_mem; mco_done/mco_rdata completion to mem_wb; mco_ram_* drive SRAM1
//        (active-low strobes, registered so they are glitch-free); mco_uart_* strobe the UART; mci_uart_* are UART status.
// Build option MEM_CTRL_UART_BLOCK_EN: UART data reads wait for data_ready before the strobe, UART data writes
// wait for tbre and tsre after the strobe. Without it, software polls the status register instead.
module mem_ctrl
  import mem_ctrl_pkg::*;
#(
  parameter int DATA_W      = 16,
  parameter int ADDR_W      = 16,
  parameter int WAIT_CYCLES = 1,
  parameter logic [ADDR_W-1:0] UART_DATA_ADDR = ADDR_W'(UART_DATA_ADDR_DEF),
  parameter logic [ADDR_W-1:0] UART_STAT_ADDR = ADDR_W'(UART_STAT_ADDR_DEF)
) (
  input  logic              mci_clk,
  input  logic              mci_rst,
  input  logic              mci_req_valid,
  input  logic              mci_req_we,
  input  logic [ADDR_W-1:0] mci_req_addr,
  input  logic [DATA_W-1:0] mci_req_wdata,
  output logic              mco_stall,
  output logic              mco_done,
  output logic [DATA_W-1:0] mco_rdata,
  output logic              mco_ram_en,
  output logic              mco_ram_we,
  output logic              mco_ram_oe,
  output logic [ADDR_W-1:0] mco_ram_addr,
  output logic [DATA_W-1:0] mco_ram_dout,
  output logic              mco_ram_doe,
  input  logic [DATA_W-1:0] mci_ram_din,
  input  logic              mci_uart_tbre,
  input  logic              mci_uart_tsre,
  input  logic              mci_uart_data_ready,
  output logic              mco_uart_wrn,
  output logic              mco_uart_rdn
);

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic [ADDR_W-1:0] ram_addr_q, ram_addr_d;
  logic              ram_en_q, ram_en_d;
  logic              ram_we_q, ram_we_d;
  logic              ram_oe_q, ram_oe_d;
  logic              ram_doe_q, ram_doe_d;
  logic              wrn_q, wrn_d;
  logic              rdn_q, rdn_d;
  logic              tmr_load, tmr_zero;
  logic [DATA_W-1:0] stat_word;
  logic [DATA_W-1:0] uart_byte;

  always_comb begin
    stat_word                = '0;
    stat_word[STAT_RX_READY] = mci_uart_data_ready;
    stat_word[STAT_TX_IDLE]  = mci_uart_tbre & mci_uart_tsre;
  end

  assign uart_byte = {{(DATA_W-8){1'b0}}, mci_ram_din[7:0]};

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    case (state_q)
      ST_IDLE: begin
        if (mci_req_valid) begin
          addr_d  = mci_req_addr;
          wdata_d = mci_req_wdata;
          if (mci_req_addr == UART_STAT_ADDR) begin
            // Status register: read completes immediately, writes are dropped.
            state_d = ST_DONE;
            if (!mci_req_we) rdata_d = stat_word;
          end else if (mci_req_addr == UART_DATA_ADDR) begin
`ifdef MEM_CTRL_UART_BLOCK_EN
            state_d = mci_req_we ? ST_UART_WR : ST_UART_RD_WAIT;
`else
            state_d = mci_req_we ? ST_UART_WR : ST_UART_RD;
`endif
          end else begin
            state_d = mci_req_we ? ST_SRAM_WR : ST_SRAM_RD;
          end
        end
      end
      ST_SRAM_RD: begin
        if (tmr_zero) begin
          rdata_d = mci_ram_din;
          state_d = ST_DONE;
        end
      end
      ST_SRAM_WR: begin
        if (tmr_zero) state_d = ST_DONE;
      end
      ST_UART_RD: begin
        if (tmr_zero) begin
          rdata_d = uart_byte;
          state_d = ST_DONE;
        end
      end
      ST_UART_WR: begin
`ifdef MEM_CTRL_UART_BLOCK_EN
        if (tmr_zero) state_d = ST_UART_WR_WAIT;
`else
        if (tmr_zero) state_d = ST_DONE;
`endif
      end
`ifdef MEM_CTRL_UART_BLOCK_EN
      ST_UART_RD_WAIT: begin
        if (mci_uart_data_ready) state_d = ST_UART_RD;
      end
      ST_UART_WR_WAIT: begin
        if (mci_uart_tbre && mci_uart_tsre) state_d = ST_DONE;
      end
`endif
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Reload the timer on entry to any strobe state so the window is always WAIT_CYCLES+1 long.
  assign tmr_load = is_strobe(state_d) && !is_strobe(state_q);

  mem_wait_timer #(
    .WAIT_CYCLES(WAIT_CYCLES)
  ) u_timer (
    .clk_i (mci_clk),
    .rst_ni(mci_rst),
    .load_i(tmr_load),
    .dec_i (is_strobe(state_q)),
    .zero_o(tmr_zero)
  );

  // Strobes and address are decoded from the next state and registered, so they change
  // together with the state and never glitch on the SRAM/UART pins.
  always_comb begin
    ram_en_d   = STROBE_OFF;
    ram_we_d   = STROBE_OFF;
    ram_oe_d   = STROBE_OFF;
    ram_doe_d  = 1'b0;
    wrn_d      = STROBE_OFF;
    rdn_d      = STROBE_OFF;
    ram_addr_d = is_strobe(state_d) ? addr_d : '0;
    case (state_d)
      ST_SRAM_RD: begin ram_en_d = STROBE_ON; ram_oe_d = STROBE_ON; end
      ST_SRAM_WR: begin ram_en_d = STROBE_ON; ram_we_d = STROBE_ON; ram_doe_d = 1'b1; end
      ST_UART_RD: rdn_d = STROBE_ON;
      ST_UART_WR: begin wrn_d = STROBE_ON; ram_doe_d = 1'b1; end
      default: ;
    endcase
  end

  always_ff @(posedge mci_clk or negedge mci_rst) begin
    if (!mci_rst) begin
      state_q    <= ST_IDLE;
      addr_q     <= '0;
      wdata_q    <= '0;
      rdata_q    <= '0;
      ram_addr_q <= '0;
      ram_en_q   <= STROBE_OFF;
      ram_we_q   <= STROBE_OFF;
      ram_oe_q   <= STROBE_OFF;
      ram_doe_q  <= 1'b0;
      wrn_q      <= STROBE_OFF;
      rdn_q      <= STROBE_OFF;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      rdata_q    <= rdata_d;
      ram_addr_q <= ram_addr_d;
      ram_en_q   <= ram_en_d;
      ram_we_q   <= ram_we_d;
      ram_oe_q   <= ram_oe_d;
      ram_doe_q  <= ram_doe_d;
      wrn_q      <= wrn_d;
      rdn_q      <= rdn_d;
    end
  end

  // In IDLE the stall follows the request combinationally; reset masks it so a held
  // request cannot freeze the pipeline while the controller is being reset.
  assign mco_stall    = (state_q == ST_IDLE) ? (mci_req_valid & mci_rst) : (state_q != ST_DONE);
  assign mco_done     = (state_q == ST_DONE);
  assign mco_rdata    = rdata_q;
  assign mco_ram_en   = ram_en_q;
  assign mco_ram_we   = ram_we_q;
  assign mco_ram_oe   = ram_oe_q;
  assign mco_ram_addr = ram_addr_q;
  assign mco_ram_dout = wdata_q;
  assign mco_ram_doe  = ram_doe_q;
  assign mco_uart_wrn = wrn_q;
  assign mco_uart_rdn = rdn_q;

endmodule
